// File: rtl/exception_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception sequencer: FSM state encoding,
// exception cause codes and the memory-address mux selector codes.
// No ports (package).
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SAVE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } cause_e;

    localparam logic [2:0] SEL_ULA_RESULT = 3'b000;
    localparam logic [2:0] SEL_ULAOUT     = 3'b001;
    localparam logic [2:0] SEL_VEC_253    = 3'b010;
    localparam logic [2:0] SEL_VEC_254    = 3'b011;
    localparam logic [2:0] SEL_VEC_255    = 3'b100;

    // Address-mux code that points at the vector byte for a given cause.
    function automatic logic [2:0] cause_to_sel(input cause_e c);
        logic [2:0] sel;
        case (c)
            CAUSE_OPCODE: sel = SEL_VEC_253;
            CAUSE_OVF:    sel = SEL_VEC_254;
            CAUSE_DIV0:   sel = SEL_VEC_255;
            default:      sel = SEL_ULA_RESULT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// -----------------------------------------------------------------------------
// exc_priority_enc
// Combinational priority encoder: three exception flags -> 2-bit cause
// (opcode_invalid > overflow > div_zero), plus the matching vector selector.
// Ports:
//   opcode_invalid, overflow, div_zero : exception flags
//   cause                              : encoded cause (CAUSE_NONE if no flag)
//   vec_sel                            : address-mux code of the vector byte
// -----------------------------------------------------------------------------
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic       opcode_invalid,
    input  logic       overflow,
    input  logic       div_zero,
    output cause_e     cause,
    output logic [2:0] vec_sel
);

    // Highest-priority active flag wins.
    always_comb begin
        cause = CAUSE_NONE;
        if (opcode_invalid) begin
            cause = CAUSE_OPCODE;
        end else if (overflow) begin
            cause = CAUSE_OVF;
        end else if (div_zero) begin
            cause = CAUSE_DIV0;
        end else begin
            cause = CAUSE_NONE;
        end
    end

    assign vec_sel = cause_to_sel(cause);

endmodule

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
// Exception sequencer for the multicycle CPU. On a flagged exception it saves
// PC-PC_OFFSET into EPC, steers the address mux to the vector byte, waits
// MEM_LATENCY cycles, loads PC with the zero-extended byte and pulses done.
// Ports:
//   clk, reset_n (sync, active-low)
//   exc_check, opcode_invalid, overflow, div_zero : trigger strobe and flags
//   pc_current, mem_data_in                       : PC to save, memory data
//   addr_sel, mem_read                            : memory-address mux / read
//   epc_write, epc_data, pc_write, pc_data        : register load ports
//   busy, done, cause                             : status
// -----------------------------------------------------------------------------
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] PC_OFFSET   = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_check,
    input  logic        opcode_invalid,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  addr_sel,
    output logic        mem_read,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cause
);

    // FETCH counter starts at MEM_LATENCY-1 so that FETCH lasts MEM_LATENCY cycles.
    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_e      state_q;
    logic [2:0]  cnt_q;
    cause_e      cause_q;
    logic [2:0]  vec_sel_q;
    logic [2:0]  addr_sel_q;
    logic        mem_read_q;
    logic        epc_write_q;
    logic [31:0] epc_data_q;
    logic        pc_write_q;
    logic        busy_q;
    logic        done_q;

    cause_e      enc_cause_s;
    logic [2:0]  enc_sel_s;

    exc_priority_enc u_enc (
        .opcode_invalid (opcode_invalid),
        .overflow       (overflow),
        .div_zero       (div_zero),
        .cause          (enc_cause_s),
        .vec_sel        (enc_sel_s)
    );

    // Sequencer FSM; every output is registered together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            cause_q     <= CAUSE_NONE;
            vec_sel_q   <= SEL_ULA_RESULT;
            addr_sel_q  <= SEL_ULA_RESULT;
            mem_read_q  <= 1'b0;
            epc_write_q <= 1'b0;
            epc_data_q  <= 32'd0;
            pc_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Single-cycle strobes drop unless the next state re-asserts them.
            mem_read_q  <= 1'b0;
            epc_write_q <= 1'b0;
            epc_data_q  <= 32'd0;
            pc_write_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    addr_sel_q <= SEL_ULA_RESULT;
                    if (exc_check && (enc_cause_s != CAUSE_NONE)) begin
                        state_q     <= ST_SAVE;
                        cause_q     <= enc_cause_s;
                        vec_sel_q   <= enc_sel_s;
                        epc_write_q <= 1'b1;
                        epc_data_q  <= pc_current - PC_OFFSET;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SAVE: begin
                    state_q    <= ST_FETCH;
                    cnt_q      <= CNT_INIT;
                    addr_sel_q <= vec_sel_q;
                    mem_read_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                ST_FETCH: begin
                    busy_q     <= 1'b1;
                    addr_sel_q <= vec_sel_q;
                    if (cnt_q == 3'd0) begin
                        state_q    <= ST_LOAD;
                        pc_write_q <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        cnt_q      <= cnt_q - 3'd1;
                        mem_read_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_DONE;
                    addr_sel_q <= SEL_ULA_RESULT;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b1;
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    addr_sel_q <= SEL_ULA_RESULT;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    addr_sel_q <= SEL_ULA_RESULT;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign addr_sel  = addr_sel_q;
    assign mem_read  = mem_read_q;
    assign epc_write = epc_write_q;
    assign epc_data  = epc_data_q;
    assign pc_write  = pc_write_q;
    // Memory data only becomes valid during LOAD, so the byte is gated through
    // rather than registered on the edge that enters LOAD.
    assign pc_data   = pc_write_q ? {24'd0, mem_data_in[7:0]} : 32'd0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exception_ctrl
// Two DUTs (MEM_LATENCY=1 and 3) share stimulus; each has its own latency-
// accurate memory model and a reference model holding the expected per-cycle
// output sequence as a queue built from the exception rules.
// -----------------------------------------------------------------------------
module tb_exception_ctrl;

    typedef struct {
        logic [2:0]  sel;
        logic        mr;
        logic        ew;
        logic [31:0] ed;
        logic        pw;
        logic [31:0] pd;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, exc_check, opcode_invalid, overflow, div_zero;
    logic [31:0] pc_current;
    logic [31:0] md1, md3;
    logic [31:0] m253, m254, m255;

    logic [2:0]  a_sel, b_sel;
    logic        a_mr, a_ew, a_pw, a_busy, a_done, b_mr, b_ew, b_pw, b_busy, b_done;
    logic [31:0] a_ed, a_pd, b_ed, b_pd;
    logic [1:0]  a_cause, b_cause;

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t scratch[$];
    exp_t cur_a, cur_b;
    logic [1:0] cause_a, cause_b;

    always #5 clk = ~clk;

    exception_ctrl #(.MEM_LATENCY(1), .PC_OFFSET(32'd4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .exc_check(exc_check),
        .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
        .pc_current(pc_current), .mem_data_in(md1),
        .addr_sel(a_sel), .mem_read(a_mr), .epc_write(a_ew), .epc_data(a_ed),
        .pc_write(a_pw), .pc_data(a_pd), .busy(a_busy), .done(a_done), .cause(a_cause)
    );

    exception_ctrl #(.MEM_LATENCY(3), .PC_OFFSET(32'd4)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .exc_check(exc_check),
        .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
        .pc_current(pc_current), .mem_data_in(md3),
        .addr_sel(b_sel), .mem_read(b_mr), .epc_write(b_ew), .epc_data(b_ed),
        .pc_write(b_pw), .pc_data(b_pd), .busy(b_busy), .done(b_done), .cause(b_cause)
    );

    // Memory behind the address mux: non-vector addresses return a junk word.
    function automatic logic [31:0] mem_at(input logic [2:0] sel);
        case (sel)
            3'b010:  return m253;
            3'b011:  return m254;
            3'b100:  return m255;
            default: return 32'hBADBAD5A;
        endcase
    endfunction

    // Read pipelines: data is valid MEM_LATENCY edges after the address.
    logic [31:0] p1;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p1    <= mem_at(a_sel);
        p3[0] <= mem_at(b_sel);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign md1 = p1;
    assign md3 = p3[2];

    function automatic exp_t mk(input logic [2:0] sel, input logic mr, input logic ew,
                                input logic [31:0] ed, input logic pw, input logic [31:0] pd,
                                input logic busy, input logic done);
        exp_t e;
        e.sel = sel; e.mr = mr; e.ew = ew; e.ed = ed;
        e.pw = pw; e.pd = pd; e.busy = busy; e.done = done;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk(3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic [1:0] cause_of(input logic op, input logic ov, input logic dz);
        if (op) return 2'd1;
        if (ov) return 2'd2;
        if (dz) return 2'd3;
        return 2'd0;
    endfunction

    // Cause -> (vector address 252+cause, selector code) from the mux table.
    function automatic logic [2:0] sel_of(input logic [1:0] c);
        logic [2:0] t [4];
        t[0] = 3'b000; t[1] = 3'b010; t[2] = 3'b011; t[3] = 3'b100;
        return t[c];
    endfunction

    function automatic logic [31:0] vec_word(input logic [1:0] c);
        int addr;
        addr = 252 + int'(c);
        if (addr == 253) return m253;
        if (addr == 254) return m254;
        return m255;
    endfunction

    // Whole expected sequence: SAVE, FETCH x latency, LOAD, DONE.
    task automatic build_seq(input int ml, input logic [1:0] c, input logic [31:0] pc);
        logic [2:0] v;
        logic [31:0] w;
        v = sel_of(c);
        w = vec_word(c);
        scratch.delete();
        scratch.push_back(mk(3'd0, 1'b0, 1'b1, pc - 32'd4, 1'b0, 32'd0, 1'b1, 1'b0));
        for (int i = 0; i < ml; i++)
            scratch.push_back(mk(v, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0));
        scratch.push_back(mk(v, 1'b0, 1'b0, 32'd0, 1'b1, {24'd0, w[7:0]}, 1'b1, 1'b0));
        scratch.push_back(mk(3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1));
    endtask

    // Advance both reference models by one clock edge using the pre-edge inputs.
    task automatic model_edge();
        logic [1:0] c;
        logic trig;
        c = cause_of(opcode_invalid, overflow, div_zero);
        trig = exc_check && (c != 2'd0);
        if (!reset_n) begin
            qa.delete(); qb.delete();
            cur_a = idle_exp(); cur_b = idle_exp();
            cause_a = 2'd0; cause_b = 2'd0;
        end else begin
            if (trig && !cur_a.busy && qa.size() == 0) begin
                build_seq(1, c, pc_current);
                foreach (scratch[i]) qa.push_back(scratch[i]);
                cause_a = c;
            end
            if (trig && !cur_b.busy && qb.size() == 0) begin
                build_seq(3, c, pc_current);
                foreach (scratch[i]) qb.push_back(scratch[i]);
                cause_b = c;
            end
            cur_a = (qa.size() > 0) ? qa.pop_front() : idle_exp();
            cur_b = (qb.size() > 0) ? qb.pop_front() : idle_exp();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("l1.addr_sel",  32'(a_sel),   32'(cur_a.sel));
        chk("l1.mem_read",  32'(a_mr),    32'(cur_a.mr));
        chk("l1.epc_write", 32'(a_ew),    32'(cur_a.ew));
        chk("l1.epc_data",  a_ed,         cur_a.ed);
        chk("l1.pc_write",  32'(a_pw),    32'(cur_a.pw));
        chk("l1.pc_data",   a_pd,         cur_a.pd);
        chk("l1.busy",      32'(a_busy),  32'(cur_a.busy));
        chk("l1.done",      32'(a_done),  32'(cur_a.done));
        chk("l1.cause",     32'(a_cause), 32'(cause_a));
        chk("l3.addr_sel",  32'(b_sel),   32'(cur_b.sel));
        chk("l3.mem_read",  32'(b_mr),    32'(cur_b.mr));
        chk("l3.epc_write", 32'(b_ew),    32'(cur_b.ew));
        chk("l3.epc_data",  b_ed,         cur_b.ed);
        chk("l3.pc_write",  32'(b_pw),    32'(cur_b.pw));
        chk("l3.pc_data",   b_pd,         cur_b.pd);
        chk("l3.busy",      32'(b_busy),  32'(cur_b.busy));
        chk("l3.done",      32'(b_done),  32'(cur_b.done));
        chk("l3.cause",     32'(b_cause), 32'(cause_b));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_in();
        exc_check = 1'b0; opcode_invalid = 1'b0; overflow = 1'b0; div_zero = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int busy_cnt;
        cur_a = idle_exp(); cur_b = idle_exp();
        cause_a = 2'd0; cause_b = 2'd0;
        m253 = 32'h0000_00A7; m254 = 32'h0000_0055; m255 = 32'h1234_56F0;
        reset_n = 1'b0; pc_current = 32'd0;
        clear_in();
        run(2);
        reset_n = 1'b1;

        // Basic opcode exception
        pc_current = 32'h0000_0040; opcode_invalid = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        busy_cnt = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (a_busy) busy_cnt++;
        end
        chk("l1.busy_cycles", 32'(busy_cnt), 32'd4);

        // Priority: overflow beats div_zero
        pc_current = 32'h0000_1000; overflow = 1'b1; div_zero = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        run(9);

        // div_zero alone
        pc_current = 32'h0000_2004; div_zero = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        run(9);

        // PC wrap, and busy length with latency 3
        pc_current = 32'd0; opcode_invalid = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        busy_cnt = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (b_busy) busy_cnt++;
        end
        chk("l3.busy_cycles", 32'(busy_cnt), 32'd6);

        // New trigger during FETCH is ignored
        pc_current = 32'h0000_0100; overflow = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        step();
        pc_current = 32'h0000_0200; opcode_invalid = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        run(8);

        // Reset during FETCH
        pc_current = 32'h0000_0300; div_zero = 1'b1; exc_check = 1'b1;
        step();
        clear_in();
        run(2);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        run(4);

        // Strobe with no flags
        exc_check = 1'b1;
        step();
        clear_in();
        run(2);

        // Reset coincident with a trigger
        reset_n = 1'b0; opcode_invalid = 1'b1; exc_check = 1'b1;
        step();
        reset_n = 1'b1;
        clear_in();
        run(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!cur_a.busy && !cur_b.busy && qa.size() == 0 && qb.size() == 0) begin
                m253 = $urandom; m254 = $urandom; m255 = $urandom;
            end
            reset_n        = ($urandom_range(0, 59) != 0);
            exc_check      = $urandom_range(0, 1) == 1;
            opcode_invalid = $urandom_range(0, 3) == 0;
            overflow       = $urandom_range(0, 2) == 0;
            div_zero       = $urandom_range(0, 2) == 0;
            pc_current     = $urandom;
            step();
        end
        reset_n = 1'b1;
        clear_in();
        run(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
